md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit beside the ALU in the E stage of the 5-stage MIPS pipeline.
- Consumes the forwarded E-stage operands (RS/RT after the forwarding muxes).
- Owns the HI/LO architectural registers.
- Raises a stall request to the hazard unit while an operation is in flight, so the pipeline freezes any later MFHI/MFLO/MULT/DIV/MTHI/MTLO in D.

Parameters:
- MUL_LAT, 5, cycles from start acceptance until a MULT/MULTU result is committed to HI/LO.
- DIV_LAT, 10, cycles from start acceptance until a DIV/DIVU result is committed to HI/LO.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  E-stage instruction is an MD op; qualified by op.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved, treated as no-op.
- rs  in  32  forwarded RS operand.
- rt  in  32  forwarded RT operand.
- busy  out  1  registered; high while a MUL/DIV is in flight.
- stall_req  out  1  combinational: start & (op is MUL/DIV) | busy; goes to the hazard unit.
- hi  out  32  HI register value, for MFHI through the E-stage result path.
- lo  out  32  LO register value, for MFLO.

Interface:
- One clock; reset is synchronous and active-low.

Behaviour:
- Reset (reset==0 at a rising edge):
  - hi=0, lo=0, busy=0, counter=0, pending results cleared, state IDLE.
  - Reset overrides any in-flight operation; the aborted result is never committed.
- States: IDLE, RUN.
- IDLE:
  - start with op 0-3: latch the computed result into pending_hi/pending_lo. Load counter with MUL_LAT (ops 0,1) or DIV_LAT (ops 2,3). Go to RUN; busy=1 from the next cycle.
  - start with MTHI: hi<=rs at this edge, no busy. MTLO: lo<=rs likewise.
- RUN:
  - Counter decrements each cycle.
  - When counter==1: hi/lo<=pending at that edge, busy<=0, go to IDLE.
  - Total: busy is high for exactly LAT cycles. The result is visible on hi/lo in the cycle after busy falls.
  - hi/lo hold their old values throughout RUN.
  - start asserted in RUN (any op, including MTHI/MTLO) is ignored. The hazard unit guarantees this does not occur; the verifier checks the state is unaffected.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
  - MULTU: unsigned, same split.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder carrying the sign of the dividend.
  - DIVU: unsigned; lo=quotient, hi=remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
  - Divide by zero (rt==0, DIV or DIVU): the operation still occupies DIV_LAT cycles with busy high, but hi/lo are left unchanged at commit.
- Operands are sampled only at the accepting edge; later changes on rs/rt have no effect.
- Back-to-back: a new start may be accepted in the same cycle busy falls (state IDLE that cycle). The earlier commit lands first, then the new operation begins.
- The pipeline sends no flush to this unit; once accepted, an op always completes unless reset.

Decomposition:
- Shared package md_pkg:
  - op encodings MD_MULT..MD_MTLO.
  - state enum IDLE/RUN.
  - counter width localparam, wide enough for max(MUL_LAT, DIV_LAT).
- One sub-module md_calc: combinational; takes op, rs, rt; returns {res_hi, res_lo, div_by_zero}. All signed/unsigned and corner-case arithmetic lives there.
- md_unit itself contains the FSM, counter, pending registers and HI/LO.

Test Plan:
- MULT: rs=0xFFFFFFFE (-2), rt=3, start 1 cycle.
  - busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULTU with the same operands: hi=0x00000002, lo=0xFFFFFFFA.
- DIV: rs=-7 (0xFFFFFFF9), rt=2.
  - busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU with the same operands: lo=0x7FFFFFFC, hi=1.
- Divide by zero: preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIVU rt=0.
  - busy 10 cycles; hi=0x11, lo=0x22 afterwards.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Interference: start MULT 4x5; during RUN assert start with MTHI rs=0xDEAD and change rs/rt.
  - Final hi=0, lo=20; MTHI ignored.
  - stall_req high from the start cycle through the last busy cycle.
- Reset: reset low on cycle 3 of a DIV.
  - Next cycle busy=0, hi=lo=0.
  - No later commit occurs; a fresh MULT 2x3 then yields lo=6.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: op codes, FSM states,
// default latencies and the width of the completion counter.
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_t;

   localparam int MD_MUL_LAT = 5;
   localparam int MD_DIV_LAT = 10;
   localparam int MD_MAX_LAT = (MD_MUL_LAT > MD_DIV_LAT) ? MD_MUL_LAT : MD_DIV_LAT;
   localparam int CNT_W      = $clog2(MD_MAX_LAT + 1);

endpackage

// File: rtl/md_calc.sv
// Combinational MULT/MULTU/DIV/DIVU datapath; zero latency, no flow control.
// Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without a trap.
module md_calc
   import md_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div_by_zero
);

   logic        is_signed;
   logic        is_div;
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] prod;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_div;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quot;
   logic [31:0] rem;

   assign is_signed = (op == MD_MULT) || (op == MD_DIV);
   assign is_div    = (op == MD_DIV)  || (op == MD_DIVU);

   // The low 64 bits of a 64x64 product are exact for both sign conventions.
   assign ext_a = {{32{is_signed & rs[31]}}, rs};
   assign ext_b = {{32{is_signed & rt[31]}}, rt};
   assign prod  = ext_a * ext_b;

   assign a_neg = is_signed & rs[31];
   assign b_neg = is_signed & rt[31];
   assign a_mag = a_neg ? -rs : rs;
   assign b_mag = b_neg ? -rt : rt;
   assign b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
   assign q_mag = a_mag / b_div;
   assign r_mag = a_mag % b_div;
   assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
   assign rem   = a_neg ? -r_mag : r_mag;

   assign res_hi      = is_div ? rem  : prod[63:32];
   assign res_lo      = is_div ? quot : prod[31:0];
   assign div_by_zero = is_div && (rt == 32'd0);

endmodule

// File: rtl/md_unit.sv
// HI/LO owner for the E stage; MUL/DIV commit MUL_LAT/DIV_LAT cycles after acceptance.
// No backpressure input: stall_req freezes later MD ops in D, and start during RUN is dropped.
module md_unit
   import md_pkg::*;
#(
   parameter int MUL_LAT = MD_MUL_LAT,
   parameter int DIV_LAT = MD_DIV_LAT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      pend_hi;
   logic [31:0]      pend_lo;
   logic             pend_dz;
   logic [31:0]      res_hi;
   logic [31:0]      res_lo;
   logic             res_dz;
   logic             is_md;

   md_calc u_calc (
      .op          (op),
      .rs          (rs),
      .rt          (rt),
      .res_hi      (res_hi),
      .res_lo      (res_lo),
      .div_by_zero (res_dz)
   );

   assign is_md     = (op[2] == 1'b0);
   assign stall_req = (start & is_md) | busy;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         cnt     <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_dz <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (is_md) begin
                     pend_hi <= res_hi;
                     pend_lo <= res_lo;
                     pend_dz <= res_dz;
                     cnt     <= op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                     busy    <= 1'b1;
                     state   <= RUN;
                  end else if (op == MD_MTHI) begin
                     hi <= rs;
                  end else if (op == MD_MTLO) begin
                     lo <= rs;
                  end
               end
            end
            RUN: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  // A zero divisor burns the full latency but leaves HI/LO untouched.
                  if (!pend_dz) begin
                     hi <= pend_hi;
                     lo <= pend_lo;
                  end
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, arithmetic corners, ignored starts, reset abort.
module tb_md_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        busy;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks;
   int n_fail;

   md_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .rs        (rs),
      .rt        (rt),
      .busy      (busy),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a one-cycle start at a falling edge; afterwards scramble the operands.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      rs    = a;
      rt    = b;
      @(negedge clk);
      start = 1'b0;
      rs    = $urandom;
      rt    = $urandom;
   endtask

   // Count falling edges with busy high, bounded so a stuck unit still terminates.
   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      start = 1'b0;
      op    = 3'd0;
      rs    = 32'h0;
      rt    = 32'h0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || stall_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b stall=%b hi=%h lo=%h, want 0/0/0/0", busy, stall_req, hi, lo);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_arith(input string name, input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] b, input int lat,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      issue(o, a, b);
      count_busy(n);
      n_checks++;
      if (n !== lat) begin
         n_fail++;
         $display("FAIL %s_latency: busy cycles=%0d, want %0d", name, n, lat);
      end
      n_checks++;
      if (hi !== exp_hi || lo !== exp_lo) begin
         n_fail++;
         $display("FAIL %s_result: hi=%h lo=%h, want hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
      end
   endtask

   task automatic test_div_zero;
      int n;
      issue(3'd4, 32'h11, 32'h0);
      n_checks++;
      if (hi !== 32'h11 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mthi: hi=%h busy=%b, want 00000011/0", hi, busy);
      end
      issue(3'd5, 32'h22, 32'h0);
      n_checks++;
      if (lo !== 32'h22 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mtlo: lo=%h busy=%b, want 00000022/0", lo, busy);
      end
      issue(3'd3, 32'h1234, 32'h0);
      count_busy(n);
      n_checks++;
      if (n !== 10) begin
         n_fail++;
         $display("FAIL divz_latency: busy cycles=%0d, want 10", n);
      end
      n_checks++;
      if (hi !== 32'h11 || lo !== 32'h22) begin
         n_fail++;
         $display("FAIL divz_result: hi=%h lo=%h, want 00000011/00000022", hi, lo);
      end
   endtask

   task automatic test_interference;
      int n;
      int n_stall;
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      old_hi = hi;
      old_lo = lo;
      start = 1'b1;
      op    = 3'd0;
      rs    = 32'd4;
      rt    = 32'd5;
      #1;
      n_checks++;
      if (stall_req !== 1'b1) begin
         n_fail++;
         $display("FAIL intf_stall_start: stall_req=%b, want 1", stall_req);
      end
      @(negedge clk);
      n = 0;
      n_stall = 0;
      while (busy === 1'b1 && n < 40) begin
         start = (n >= 1 && n <= 3);
         op    = 3'd4;
         rs    = 32'hDEAD;
         rt    = $urandom;
         #1;
         if (stall_req === 1'b1) n_stall++;
         if (hi !== old_hi || lo !== old_lo) begin
            n_checks++;
            n_fail++;
            $display("FAIL intf_hold: hi=%h lo=%h during RUN, want %h/%h", hi, lo, old_hi, old_lo);
         end
         n++;
         @(negedge clk);
      end
      start = 1'b0;
      #1;
      n_checks++;
      if (n !== 5 || n_stall !== 5 || stall_req !== 1'b0) begin
         n_fail++;
         $display("FAIL intf_timing: busy=%0d stall=%0d stall_after=%b, want 5/5/0", n, n_stall, stall_req);
      end
      n_checks++;
      if (hi !== 32'h0 || lo !== 32'd20) begin
         n_fail++;
         $display("FAIL intf_result: hi=%h lo=%h, want 00000000/00000014", hi, lo);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int n;
      issue(3'd1, 32'd3, 32'd3);
      count_busy(n);
      n_checks++;
      if (lo !== 32'd9 || hi !== 32'd0 || n !== 5) begin
         n_fail++;
         $display("FAIL b2b_first: hi=%h lo=%h busy=%0d, want 0/9/5", hi, lo, n);
      end
      issue(3'd3, 32'd100, 32'd7);
      n_checks++;
      if (busy !== 1'b1 || lo !== 32'd9) begin
         n_fail++;
         $display("FAIL b2b_accept: busy=%b lo=%h, want 1/00000009", busy, lo);
      end
      count_busy(n);
      n_checks++;
      if (lo !== 32'd14 || hi !== 32'd2 || n !== 10) begin
         n_fail++;
         $display("FAIL b2b_second: hi=%h lo=%h busy=%0d, want 2/14/10", hi, lo, n);
      end
   endtask

   task automatic test_reset_abort;
      int n;
      issue(3'd2, 32'd100, 32'd7);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         n_fail++;
         $display("FAIL abort_reset: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
      end
      reset = 1'b1;
      repeat (12) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         n_fail++;
         $display("FAIL abort_no_commit: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
      end
      issue(3'd0, 32'd2, 32'd3);
      count_busy(n);
      n_checks++;
      if (lo !== 32'd6 || hi !== 32'd0 || n !== 5) begin
         n_fail++;
         $display("FAIL abort_fresh_mult: hi=%h lo=%h busy=%0d, want 0/6/5", hi, lo, n);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_arith("mult",  3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
      test_arith("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
      test_arith("div",   3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      test_arith("divu",  3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC);
      test_div_zero();
      test_arith("ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
      test_arith("rsv",   3'd2, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
      test_interference();
      test_back_to_back();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
